// File: rtl/uart_rx_if.sv
// Receive-side byte interface of the UART: serial line in, framed byte and status out.
interface uart_rx_if;
  logic       rx_in;
  logic [7:0] rx_byte;
  logic       rx_complete;
  logic       rx_frame_error;
  logic       rx_busy;

  modport master (
    input  rx_in,
    output rx_byte, rx_complete, rx_frame_error, rx_busy
  );

  modport slave (
    output rx_in,
    input  rx_byte, rx_complete, rx_frame_error, rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling from a fractional accumulator, mid-bit sampling,
// one-cycle completion / frame-error strobes.
module uart_rx #(
  parameter int unsigned SOURCE_FREQ       = 25_000_000,
  parameter int unsigned BAUD              = 115200,
  parameter int unsigned ACCUMULATOR_WIDTH = 16
) (
  input  logic      sourceClk,
  input  logic      reset,
  uart_rx_if.master rx
);

  localparam int unsigned AW = ACCUMULATOR_WIDTH;
  localparam longint unsigned BAUD_L = BAUD;
  localparam longint unsigned FREQ_L = SOURCE_FREQ;
  // Rounded phase increment giving 16 ticks per bit period.
  localparam longint unsigned INC_L =
    (((BAUD_L * 64'd16) << (AW - 4)) + (FREQ_L >> 5)) / (FREQ_L >> 4);
  localparam logic [AW:0] INC = (AW + 1)'(INC_L);

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop,
    RxWaitHigh
  } state_t;

  state_t      state, state_n;
  logic        rx_m, rx_s;
  logic [AW:0] acc, acc_n;
  logic        tick;
  logic [3:0]  sub_cnt, sub_n;
  logic [2:0]  bit_cnt, bit_n;
  logic [7:0]  shift_q, shift_n;
  logic [7:0]  byte_q, byte_n;
  logic        complete_q, complete_n;
  logic        ferr_q, ferr_n;

  assign tick = acc[AW];

  always_ff @(posedge sourceClk) begin
    if (!reset) begin
      state      <= RxIdle;
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      acc        <= '0;
      sub_cnt    <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      byte_q     <= '0;
      complete_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state      <= state_n;
      rx_m       <= rx.rx_in;
      rx_s       <= rx_m;
      acc        <= acc_n;
      sub_cnt    <= sub_n;
      bit_cnt    <= bit_n;
      shift_q    <= shift_n;
      byte_q     <= byte_n;
      complete_q <= complete_n;
      ferr_q     <= ferr_n;
    end
  end

  always_comb begin
    // MSB is always dropped before adding: it only carries the tick just consumed.
    acc_n      = {1'b0, acc[AW-1:0]} + INC;
    state_n    = state;
    sub_n      = tick ? sub_cnt + 4'd1 : sub_cnt;
    bit_n      = bit_cnt;
    shift_n    = shift_q;
    byte_n     = byte_q;
    complete_n = 1'b0;
    ferr_n     = 1'b0;

    case (state)
      RxIdle: begin
        if (!rx_s) begin
          acc_n   = '0;
          sub_n   = '0;
          state_n = RxStart;
        end
      end
      RxStart: begin
        if (tick && sub_cnt == 4'd7) begin
          if (rx_s) begin
            state_n = RxIdle;
          end else begin
            sub_n   = '0;
            bit_n   = '0;
            state_n = RxData;
          end
        end
      end
      RxData: begin
        if (tick && sub_cnt == 4'd15) begin
          shift_n = {rx_s, shift_q[7:1]};
          bit_n   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_n = RxStop;
          end
        end
      end
      RxStop: begin
        if (tick && sub_cnt == 4'd15) begin
          if (rx_s) begin
            byte_n     = shift_q;
            complete_n = 1'b1;
            state_n    = RxIdle;
          end else begin
            ferr_n     = 1'b1;
            state_n    = RxWaitHigh;
          end
        end
      end
      RxWaitHigh: begin
        if (rx_s) begin
          state_n = RxIdle;
        end
      end
      default: state_n = RxIdle;
    endcase
  end

  assign rx.rx_byte        = byte_q;
  assign rx.rx_complete    = complete_q;
  assign rx.rx_frame_error = ferr_q;
  assign rx.rx_busy        = (state != RxIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: framing, glitch rejection, frame error, reset, baud tolerance, latency.
module tb_uart_rx;

  logic sourceClk = 1'b0;
  logic reset     = 1'b0;

  uart_rx_if rx ();

  uart_rx #(
    .SOURCE_FREQ      (25_000_000),
    .BAUD             (115200),
    .ACCUMULATOR_WIDTH(16)
  ) dut (
    .sourceClk(sourceClk),
    .reset    (reset),
    .rx       (rx.master)
  );

  always #20 sourceClk = ~sourceClk;

  int unsigned cyc = 0;
  always @(posedge sourceClk) cyc <= cyc + 1;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: strobe counts, received bytes, protocol violations, timing marks.
  logic [7:0]  got_q[$];
  int unsigned n_complete = 0;
  int unsigned n_ferr     = 0;
  int unsigned n_illegal  = 0;
  int unsigned n_busy     = 0;
  int unsigned busy_rise_cyc = 0;
  int unsigned complete_cyc  = 0;
  logic prev_c = 1'b0, prev_f = 1'b0, prev_b = 1'b0;

  always @(negedge sourceClk) begin
    if (rx.rx_complete) begin
      n_complete++;
      complete_cyc = cyc;
      got_q.push_back(rx.rx_byte);
    end
    if (rx.rx_frame_error) n_ferr++;
    if ((rx.rx_complete && rx.rx_frame_error) ||
        (rx.rx_complete && prev_c) || (rx.rx_frame_error && prev_f))
      n_illegal++;
    if (rx.rx_busy && !prev_b) begin
      n_busy++;
      busy_rise_cyc = cyc;
    end
    prev_c = rx.rx_complete;
    prev_f = rx.rx_frame_error;
    prev_b = rx.rx_busy;
  end

  int unsigned t0 = 0;

  // All stimulus tasks start and end on a falling clock edge.
  task automatic drive_bit(input logic v, input int unsigned n);
    rx.rx_in = v;
    repeat (n) @(negedge sourceClk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int unsigned bc, input logic stop_v);
    t0 = cyc;
    drive_bit(1'b0, bc);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bc);
    drive_bit(stop_v, bc);
    rx.rx_in = 1'b1;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    logic [31:0] obs;
    obs = (got_q.size() != 0) ? {24'h0, got_q.pop_front()} : 32'hDEAD_BEEF;
    check(tag, obs, {24'h0, exp});
  endtask

  initial begin
    rx.rx_in = 1'b1;
    reset    = 1'b0;
    repeat (4) @(negedge sourceClk);
    check("rst_byte", {24'h0, rx.rx_byte}, 32'h00);
    check("rst_cmpl", {31'h0, rx.rx_complete}, 32'h0);
    check("rst_ferr", {31'h0, rx.rx_frame_error}, 32'h0);
    check("rst_busy", {31'h0, rx.rx_busy}, 32'h0);
    reset = 1'b1;
    repeat (20) @(negedge sourceClk);

    // 60-cycle glitch: start rejected at mid start bit, no strobe.
    drive_bit(1'b0, 60);
    drive_bit(1'b1, 400);
    check("glitch_busy_seen", n_busy, 1);
    check("glitch_busy_now", {31'h0, rx.rx_busy}, 32'h0);
    check("glitch_cmpl", n_complete, 0);
    check("glitch_ferr", n_ferr, 0);
    check("glitch_byte", {24'h0, rx.rx_byte}, 32'h00);

    // Back-to-back frames.
    send_frame(8'h55, 217, 1'b1);
    check("busy_rise_55", busy_rise_cyc - t0, 3);
    send_frame(8'hA3, 217, 1'b1);
    drive_bit(1'b1, 100);
    expect_byte("byte_55", 8'h55);
    expect_byte("byte_A3", 8'hA3);
    check("b2b_ferr", n_ferr, 0);
    check("b2b_cmpl", n_complete, 2);

    // Stop bit low, line then held low: one frame error, wait for line high.
    send_frame(8'h3C, 217, 1'b0);
    drive_bit(1'b0, 3 * 217);
    check("ferr_count", n_ferr, 1);
    check("ferr_busy_hold", {31'h0, rx.rx_busy}, 32'h1);
    check("ferr_byte_kept", {24'h0, rx.rx_byte}, 32'hA3);
    drive_bit(1'b1, 5);
    check("ferr_idle", {31'h0, rx.rx_busy}, 32'h0);
    drive_bit(1'b1, 300);
    check("ferr_no_cmpl", n_complete, 2);
    check("ferr_no_restart", {31'h0, rx.rx_busy}, 32'h0);

    // Reset pulse inside data bit 4 of 0xFF.
    drive_bit(1'b0, 217);
    drive_bit(1'b1, 4 * 217 + 100);
    reset = 1'b0;
    @(negedge sourceClk);
    reset = 1'b1;
    check("mid_rst_byte", {24'h0, rx.rx_byte}, 32'h00);
    check("mid_rst_busy", {31'h0, rx.rx_busy}, 32'h0);
    check("mid_rst_cmpl", {31'h0, rx.rx_complete}, 32'h0);
    check("mid_rst_ferr", {31'h0, rx.rx_frame_error}, 32'h0);
    drive_bit(1'b1, 2000);
    check("mid_rst_no_strobe", n_complete + n_ferr, 3);
    send_frame(8'h81, 217, 1'b1);
    drive_bit(1'b1, 50);
    expect_byte("byte_81", 8'h81);

    // Baud +3% (211 cycles/bit) and -3% (224 cycles/bit).
    send_frame(8'h00, 211, 1'b1);
    send_frame(8'hFF, 211, 1'b1);
    drive_bit(1'b1, 100);
    expect_byte("fast_00", 8'h00);
    expect_byte("fast_FF", 8'hFF);
    send_frame(8'h00, 224, 1'b1);
    send_frame(8'hFF, 224, 1'b1);
    drive_bit(1'b1, 100);
    expect_byte("slow_00", 8'h00);
    expect_byte("slow_FF", 8'hFF);
    check("tol_ferr", n_ferr, 1);

    // Completion latency target t0 + 2064.5 cycles, +/-14.
    send_frame(8'h96, 217, 1'b1);
    drive_bit(1'b1, 50);
    expect_byte("byte_96", 8'h96);
    check("busy_rise_96", busy_rise_cyc - t0, 3);
    check("lat_96", {31'h0, (complete_cyc >= t0 + 2051) && (complete_cyc <= t0 + 2078)}, 32'h1);

    check("strobe_rules", n_illegal, 0);
    check("total_cmpl", n_complete, 8);
    check("queue_empty", got_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
